// File: rtl/superpixel_draw_sched_pkg.sv
// Shared constants, command payload and FSM encoding for the superpixel draw scheduler.
package superpixel_draw_sched_pkg;

  localparam int unsigned SPIXEL_X_WIDTH = 6;
  localparam int unsigned SPIXEL_Y_WIDTH = 6;
  localparam int unsigned COLOR_ID_WIDTH = 8;
  localparam int unsigned FIFO_AW        = 4;
  localparam int unsigned FIFO_DEPTH     = 2 ** FIFO_AW;
  localparam int unsigned FIFO_CNT_W     = FIFO_AW + 1;

  localparam logic [SPIXEL_X_WIDTH-1:0] SPIXEL_X_MAX = 6'd63;
  localparam logic [SPIXEL_Y_WIDTH-1:0] SPIXEL_Y_MAX = 6'd47;

  // One queued draw request
  typedef struct packed {
    logic [SPIXEL_X_WIDTH-1:0] x;
    logic [SPIXEL_Y_WIDTH-1:0] y;
    logic [COLOR_ID_WIDTH-1:0] color;
  } spixel_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CLR_ISSUE,
    ST_CLR_WAIT
  } sched_state_t;

endpackage

// File: rtl/superpixel_draw_sched_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count and drop flag.
module spixel_cmd_fifo
  import superpixel_draw_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  spixel_cmd_t           din,
  input  logic                  pop,
  output spixel_cmd_t           dout,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  drop
);

  spixel_cmd_t        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Full/empty come straight from the registered count, so a pop in the same
  // cycle never frees room for a push.
  assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, count and the one-cycle drop pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: count <= count;
      endcase
      drop <= push && full;
    end
  end

endmodule

// File: rtl/superpixel_draw_sched.sv
// Issues queued superpixel draw commands and full-screen clear sweeps to the draw engine,
// one at a time, handshaking on the engine's done pulse.
module superpixel_draw_sched
  import superpixel_draw_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SPIXEL_X_WIDTH-1:0] ix,
  input  logic [SPIXEL_Y_WIDTH-1:0] iy,
  input  logic [COLOR_ID_WIDTH-1:0] icolor,
  input  logic                      ipush,
  output logic                      ofull,
  output logic                      odrop,
  input  logic                      iclear,
  input  logic [COLOR_ID_WIDTH-1:0] iclear_color,
  output logic                      oclear_busy,
  output logic [SPIXEL_X_WIDTH-1:0] ox,
  output logic [SPIXEL_Y_WIDTH-1:0] oy,
  output logic [COLOR_ID_WIDTH-1:0] odata,
  output logic                      odata_vld,
  input  logic                      idone,
  output logic                      obusy
);

  sched_state_t              state;
  sched_state_t              state_nxt;
  logic [SPIXEL_X_WIDTH-1:0] x_q;
  logic [SPIXEL_X_WIDTH-1:0] x_nxt;
  logic [SPIXEL_Y_WIDTH-1:0] y_q;
  logic [SPIXEL_Y_WIDTH-1:0] y_nxt;
  logic [COLOR_ID_WIDTH-1:0] data_q;
  logic [COLOR_ID_WIDTH-1:0] data_nxt;
  logic                      clr_pend;
  logic                      clr_pend_nxt;
  logic [COLOR_ID_WIDTH-1:0] clr_color;
  logic [COLOR_ID_WIDTH-1:0] clr_color_nxt;
  logic                      pop;
  spixel_cmd_t               push_cmd;
  spixel_cmd_t               head;
  logic [FIFO_CNT_W-1:0]     fifo_count;
  logic                      fifo_empty;
  logic                      sweep_last;

  assign push_cmd = '{x: ix, y: iy, color: icolor};

  spixel_cmd_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ipush),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (ofull),
    .empty (fifo_empty),
    .drop  (odrop)
  );

  // The output registers double as the clear sweep position counters
  assign sweep_last  = (x_q == SPIXEL_X_MAX) && (y_q == SPIXEL_Y_MAX);
  assign ox          = x_q;
  assign oy          = y_q;
  assign odata       = data_q;
  assign odata_vld   = (state == ST_ISSUE) || (state == ST_CLR_ISSUE);
  assign oclear_busy = clr_pend;
  assign obusy       = (state != ST_IDLE) || (fifo_count != '0) || clr_pend;

  // Next-state, command load, sweep stepping and clear acceptance
  always_comb begin
    state_nxt     = state;
    x_nxt         = x_q;
    y_nxt         = y_q;
    data_nxt      = data_q;
    clr_pend_nxt  = clr_pend;
    clr_color_nxt = clr_color;
    pop           = 1'b0;

    if (iclear && !clr_pend) begin
      clr_pend_nxt  = 1'b1;
      clr_color_nxt = iclear_color;
    end

    unique case (state)
      ST_IDLE: begin
        if (clr_pend) begin
          x_nxt     = '0;
          y_nxt     = '0;
          data_nxt  = clr_color;
          state_nxt = ST_CLR_ISSUE;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          x_nxt     = head.x;
          y_nxt     = head.y;
          data_nxt  = head.color;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (idone) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CLR_ISSUE: begin
        state_nxt = ST_CLR_WAIT;
      end
      ST_CLR_WAIT: begin
        if (idone) begin
          if (sweep_last) begin
            clr_pend_nxt = 1'b0;
            state_nxt    = ST_IDLE;
          end else begin
            if (x_q == SPIXEL_X_MAX) begin
              x_nxt = '0;
              y_nxt = y_q + SPIXEL_Y_WIDTH'(1);
            end else begin
              x_nxt = x_q + SPIXEL_X_WIDTH'(1);
            end
            state_nxt = ST_CLR_ISSUE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      data_q    <= '0;
      clr_pend  <= 1'b0;
      clr_color <= '0;
    end else begin
      state     <= state_nxt;
      x_q       <= x_nxt;
      y_q       <= y_nxt;
      data_q    <= data_nxt;
      clr_pend  <= clr_pend_nxt;
      clr_color <= clr_color_nxt;
    end
  end

endmodule

// File: tb/tb_superpixel_draw_sched.sv
// Directed bench for superpixel_draw_sched with a simple delayed-done engine model.
module tb_superpixel_draw_sched;
  import superpixel_draw_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] ix = '0;
  logic [5:0] iy = '0;
  logic [7:0] icolor = '0;
  logic       ipush = 1'b0;
  logic       ofull;
  logic       odrop;
  logic       iclear = 1'b0;
  logic [7:0] iclear_color = '0;
  logic       oclear_busy;
  logic [5:0] ox;
  logic [5:0] oy;
  logic [7:0] odata;
  logic       odata_vld;
  logic       idone = 1'b0;
  logic       obusy;

  int n_tests = 0;
  int n_fail  = 0;

  // Engine model: eng_delay > 0 returns idone that many cycles after each odata_vld,
  // eng_delay == 0 stalls until the bench pulses idone by hand.
  int          eng_delay = 0;
  int          done_cnt  = 0;
  int          vld_long  = 0;
  logic        prev_vld  = 1'b0;
  logic [21:0] vld_log[$];
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  superpixel_draw_sched dut (
    .clk          (clk),
    .rst          (rst),
    .ix           (ix),
    .iy           (iy),
    .icolor       (icolor),
    .ipush        (ipush),
    .ofull        (ofull),
    .odrop        (odrop),
    .iclear       (iclear),
    .iclear_color (iclear_color),
    .oclear_busy  (oclear_busy),
    .ox           (ox),
    .oy           (oy),
    .odata        (odata),
    .odata_vld    (odata_vld),
    .idone        (idone),
    .obusy        (obusy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] pk(input int x, input int y, input int c);
    return {6'(x), 6'(y), 8'(c)};
  endfunction

  // One clock; sample outputs 1ns after the edge and run the engine model
  task automatic tick();
    @(posedge clk);
    #1;
    idone = 1'b0;
    if (odata_vld) begin
      vld_log.push_back({ox, oy, odata});
      if (prev_vld) vld_long++;
      if (eng_delay > 0) done_cnt = eng_delay;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) idone = 1'b1;
    end
    prev_vld = odata_vld;
  endtask

  task automatic pulse_done();
    idone = 1'b1;
    tick();
  endtask

  task automatic push(input int x, input int y, input int c);
    ix     = 6'(x);
    iy     = 6'(y);
    icolor = 8'(c);
    ipush  = 1'b1;
    tick();
    ipush  = 1'b0;
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && vld_log.size() < n; i++) tick();
    check(tag, 32'(vld_log.size()), 32'(n));
  endtask

  task automatic check_log(input string tag);
    int err = 0;
    check({tag, "_count"}, 32'(vld_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < vld_log.size(); i++) begin
      if (vld_log[i] !== exp_q[i]) begin
        err++;
        if (err <= 3) $display("  %s entry %0d got %h want %h", tag, i, vld_log[i], exp_q[i]);
      end
    end
    check({tag, "_order"}, 32'(err), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"},   32'(odata_vld),   32'd0);
    check({tag, "_busy"},  32'(obusy),       32'd0);
    check({tag, "_full"},  32'(ofull),       32'd0);
    check({tag, "_drop"},  32'(odrop),       32'd0);
    check({tag, "_clr"},   32'(oclear_busy), 32'd0);
    check({tag, "_ox"},    32'(ox),          32'd0);
    check({tag, "_oy"},    32'(oy),          32'd0);
    check({tag, "_odata"}, 32'(odata),       32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_all_zero("rst");
    rst = 1'b0;
    tick();

    // Single command with a slow engine
    eng_delay = 100;
    done_cnt  = 0;
    push(3, 4, 8'h1F);
    check("t1_busy_after_push", 32'(obusy), 32'd1);
    wait_log("t1_issued", 1, 20);
    for (int i = 0; i < 150 && !idone; i++) tick();
    check("t1_done_seen", 32'(idone), 32'd1);
    check("t1_busy_at_done", 32'(obusy), 32'd1);
    tick();
    check("t1_busy_fall", 32'(obusy), 32'd0);
    check("t1_cmd", 32'(vld_log[0]), 32'(pk(3, 4, 8'h1F)));
    repeat (5) tick();
    check("t1_one_pulse", 32'(vld_log.size()), 32'd1);
    pulse_done();
    tick();
    check("idle_done_busy", 32'(obusy), 32'd0);
    check("idle_done_novld", 32'(vld_log.size()), 32'd1);

    // Fill the FIFO behind a stalled command, then overflow by one
    eng_delay = 0;
    done_cnt  = 0;
    vld_log.delete();
    exp_q.delete();
    push(1, 2, 8'h80);
    exp_q.push_back(pk(1, 2, 8'h80));
    wait_log("t2_head_issued", 1, 10);
    ipush = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ix     = 6'(i);
      iy     = 6'(i + 20);
      icolor = 8'(8'h10 + i);
      exp_q.push_back(pk(i, i + 20, 8'h10 + i));
      tick();
      if (i == 14) check("t2_not_full_15", 32'(ofull), 32'd0);
    end
    check("t2_full_16", 32'(ofull), 32'd1);
    check("t2_no_drop_16", 32'(odrop), 32'd0);
    ix     = 6'd50;
    iy     = 6'd50;
    icolor = 8'hEE;
    tick();
    ipush = 1'b0;
    check("t2_drop_pulse", 32'(odrop), 32'd1);
    check("t2_still_full", 32'(ofull), 32'd1);
    tick();
    check("t2_drop_clear", 32'(odrop), 32'd0);
    eng_delay = 1;
    pulse_done();
    wait_log("t2_drained", 17, 200);
    repeat (10) tick();
    check_log("t2");
    check("t2_idle", 32'(obusy), 32'd0);

    // Simultaneous push and pop at count 5 keeps the count at 5
    eng_delay = 0;
    done_cnt  = 0;
    vld_log.delete();
    exp_q.delete();
    push(7, 7, 8'h01);
    exp_q.push_back(pk(7, 7, 8'h01));
    wait_log("t3_head_issued", 1, 10);
    for (int i = 0; i < 5; i++) begin
      push(i + 1, i + 2, 8'h20 + i);
      exp_q.push_back(pk(i + 1, i + 2, 8'h20 + i));
    end
    pulse_done();
    push(9, 9, 8'h2F);
    exp_q.push_back(pk(9, 9, 8'h2F));
    check("t3_no_drop", 32'(odrop), 32'd0);
    check("t3_not_full", 32'(ofull), 32'd0);
    ipush = 1'b1;
    for (int i = 0; i < 11; i++) begin
      ix     = 6'(30 + i);
      iy     = 6'(i);
      icolor = 8'(8'h60 + i);
      exp_q.push_back(pk(30 + i, i, 8'h60 + i));
      tick();
      if (i == 9) check("t3_not_full_15", 32'(ofull), 32'd0);
    end
    ipush = 1'b0;
    check("t3_full_16", 32'(ofull), 32'd1);
    check("t3_no_drop_16", 32'(odrop), 32'd0);
    eng_delay = 1;
    pulse_done();
    wait_log("t3_drained", 18, 300);
    repeat (10) tick();
    check_log("t3");

    // Full-screen clear, with a push and an ignored second clear during the sweep
    eng_delay = 2;
    done_cnt  = 0;
    vld_log.delete();
    exp_q.delete();
    iclear       = 1'b1;
    iclear_color = 8'h02;
    tick();
    iclear = 1'b0;
    check("t4_clear_busy", 32'(oclear_busy), 32'd1);
    check("t4_busy", 32'(obusy), 32'd1);
    for (int yy = 0; yy <= 47; yy++)
      for (int xx = 0; xx <= 63; xx++)
        exp_q.push_back(pk(xx, yy, 8'h02));
    repeat (50) tick();
    push(5, 6, 8'hAA);
    iclear       = 1'b1;
    iclear_color = 8'h77;
    tick();
    iclear = 1'b0;
    check("t4_clear_still_busy", 32'(oclear_busy), 32'd1);
    for (int i = 0; i < 12000 && oclear_busy; i++) tick();
    check("t4_clear_done", 32'(oclear_busy), 32'd0);
    check("t4_cmd_after_sweep", 32'(vld_log.size()), 32'd3072);
    exp_q.push_back(pk(5, 6, 8'hAA));
    repeat (20) tick();
    check_log("t4");
    check("t4_first", 32'(vld_log[0]), 32'(pk(0, 0, 8'h02)));
    check("t4_row0_end", 32'(vld_log[63]), 32'(pk(63, 0, 8'h02)));
    check("t4_wrap", 32'(vld_log[64]), 32'(pk(0, 1, 8'h02)));
    check("t4_last", 32'(vld_log[3071]), 32'(pk(63, 47, 8'h02)));
    check("t4_no_resweep", 32'(oclear_busy), 32'd0);

    // Reset while waiting on the engine with three commands queued
    eng_delay = 0;
    done_cnt  = 0;
    vld_log.delete();
    push(10, 11, 8'h33);
    push(12, 13, 8'h34);
    push(14, 15, 8'h35);
    push(16, 17, 8'h36);
    tick();
    check("t5_pre_ox", 32'(ox), 32'd10);
    check("t5_pre_busy", 32'(obusy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t5_async");
    tick();
    rst = 1'b0;
    eng_delay = 1;
    repeat (30) tick();
    check("t5_no_reissue", 32'(vld_log.size()), 32'd1);
    check("t5_idle", 32'(obusy), 32'd0);

    check("vld_one_cycle", 32'(vld_long), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
